// File: rtl/conv_pkg.sv
// Shared constants and encodings for the convolveX window path (feeder and engine).
package conv_pkg;

  localparam int KERNEL_SIZE_DEF = 3;
  localparam int WIN_N           = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_START     = 2'd1,
    RD_WAIT_DONE = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    SET_EMPTY = 2'd0,
    SET_FULL  = 2'd1,
    SET_BUSY  = 2'd2
  } set_status_e;

  function automatic int win_pixels(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/conv_window_bank.sv
// One window bank: DEPTH x DATA_WIDTH register file, synchronous write, asynchronous read.
// Reads at addresses past DEPTH return zero.
module conv_window_bank #(
  parameter int DEPTH      = 9,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_we && (i_waddr == ADDR_WIDTH'(i))) mem_d[i] = i_wdata;
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_raddr == ADDR_WIDTH'(i)) o_rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Packs a pixel stream into double-buffered window pairs (sets A/B) and serves
// them to convolveX through a zero-latency address-driven read port.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE     = KERNEL_SIZE_DEF,
  parameter int DATA_WIDTH      = 8,
  parameter int SRAM_ADDR_WIDTH = 4,
  parameter int SRAM_DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_pix_valid,
  input  logic [DATA_WIDTH-1:0]      i_pix_data,
  output logic                       o_pix_ready,
  output logic                       o_conv_start,
  input  logic                       i_conv_done,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_window_addr,
  output logic [DATA_WIDTH-1:0]      o_window1_data,
  output logic [DATA_WIDTH-1:0]      o_window2_data,
  output logic [7:0]                 o_pair_count
);

  localparam int N        = win_pixels(KERNEL_SIZE);
  localparam int CW       = $clog2(2 * N);
  localparam int RD_WORDS = (N < SRAM_DEPTH) ? N : SRAM_DEPTH;
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(2 * N - 1);

  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic          fill_set_q, fill_set_d;
  logic          rd_set_q, rd_set_d;
  set_status_e   status_q [2];
  set_status_e   status_d [2];
  rd_state_e     state_q, state_d;
  logic          conv_start_q, conv_start_d;
  logic [7:0]    pair_count_q, pair_count_d;
  logic          done_dly_q, done_dly_d;

  logic                       xfer, in_win2, fill_last, done_event;
  logic [CW-1:0]              word_idx;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]                 bank_we;
  logic [DATA_WIDTH-1:0]      bank_rdata [4];

  // Pixel handshake: a pixel moves when i_pix_valid && o_pix_ready at a rising
  // edge; ready depends only on the fill set being EMPTY, never on valid.
  assign o_pix_ready = (status_q[fill_set_q] == SET_EMPTY);
  assign xfer        = i_pix_valid & o_pix_ready;
  assign in_win2     = (fill_cnt_q >= N_C);
  assign fill_last   = (fill_cnt_q == LAST_C);
  assign word_idx    = in_win2 ? (fill_cnt_q - N_C) : fill_cnt_q;
  assign wr_addr     = SRAM_ADDR_WIDTH'(word_idx);
  assign done_event  = i_conv_done & ~done_dly_q;

  // Bank index is {set, window}: 0=A/win1, 1=A/win2, 2=B/win1, 3=B/win2.
  always_comb begin
    bank_we = '0;
    bank_we[{fill_set_q, in_win2}] = xfer;
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    conv_window_bank #(
      .DEPTH      (RD_WORDS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (SRAM_ADDR_WIDTH)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (bank_we[b]),
      .i_waddr (wr_addr),
      .i_wdata (i_pix_data),
      .i_raddr (i_window_addr),
      .o_rdata (bank_rdata[b])
    );
  end

  assign o_window1_data = bank_rdata[{rd_set_q, 1'b0}];
  assign o_window2_data = bank_rdata[{rd_set_q, 1'b1}];
  assign o_conv_start   = conv_start_q;
  assign o_pair_count   = pair_count_q;

  // Fill completion and release always land on different sets, so both
  // updates to status_d can apply in the same cycle.
  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    fill_set_d   = fill_set_q;
    rd_set_d     = rd_set_q;
    status_d     = status_q;
    state_d      = state_q;
    conv_start_d = 1'b0;
    pair_count_d = pair_count_q;
    done_dly_d   = i_conv_done;

    if (xfer) begin
      if (fill_last) begin
        fill_cnt_d           = '0;
        status_d[fill_set_q] = SET_FULL;
        fill_set_d           = ~fill_set_q;
      end else begin
        fill_cnt_d = fill_cnt_q + CW'(1);
      end
    end

    case (state_q)
      RD_IDLE: begin
        if (status_q[rd_set_q] == SET_FULL) begin
          state_d      = RD_START;
          conv_start_d = 1'b1;
        end
      end
      RD_START: begin
        status_d[rd_set_q] = SET_BUSY;
        state_d            = RD_WAIT_DONE;
      end
      RD_WAIT_DONE: begin
        if (done_event) begin
          status_d[rd_set_q] = SET_EMPTY;
          rd_set_d           = ~rd_set_q;
          pair_count_d       = pair_count_q + 8'd1;
          state_d            = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_cnt_q   <= '0;
      fill_set_q   <= 1'b0;
      rd_set_q     <= 1'b0;
      status_q[0]  <= SET_EMPTY;
      status_q[1]  <= SET_EMPTY;
      state_q      <= RD_IDLE;
      conv_start_q <= 1'b0;
      pair_count_q <= 8'd0;
      done_dly_q   <= 1'b0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      fill_set_q   <= fill_set_d;
      rd_set_q     <= rd_set_d;
      status_q     <= status_d;
      state_q      <= state_d;
      conv_start_q <= conv_start_d;
      pair_count_q <= pair_count_d;
      done_dly_q   <= done_dly_d;
    end
  end

  a_no_write_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (|bank_we) |-> (status_q[fill_set_q] != SET_BUSY));

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: pixel driver plus a background engine model that
// reads each served window pair against the scoreboard and answers with done.
module tb_conv_window_feeder;

  localparam int N  = 9;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_pix_valid = 1'b0;
  logic [DW-1:0] i_pix_data = '0;
  logic          o_pix_ready;
  logic          o_conv_start;
  logic          i_conv_done;
  logic [AW-1:0] i_window_addr = '0;
  logic [DW-1:0] o_window1_data;
  logic [DW-1:0] o_window2_data;
  logic [7:0]    o_pair_count;

  logic eng_done = 1'b0;
  logic tb_done  = 1'b0;
  assign i_conv_done = eng_done | tb_done;

  logic [DW-1:0] exp_q[$];
  logic [7:0]    exp_pairs = 8'd0;
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int releases = 0;
  int done_delay = 20;
  int done_hold = 1;
  bit withhold = 1'b0;

  conv_window_feeder #(
    .KERNEL_SIZE(3), .DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .SRAM_DEPTH(16)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pix_valid    (i_pix_valid),
    .i_pix_data     (i_pix_data),
    .o_pix_ready    (o_pix_ready),
    .o_conv_start   (o_conv_start),
    .i_conv_done    (i_conv_done),
    .i_window_addr  (i_window_addr),
    .o_window1_data (o_window1_data),
    .o_window2_data (o_window2_data),
    .o_pair_count   (o_pair_count)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [DW-1:0] d, input bit gap);
    bit acc;
    int n;
    if (gap) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge i_clk); #1;
      end
    end
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 400) begin
      acc = o_pix_ready;
      @(posedge i_clk); #1;
      n++;
    end
    i_pix_valid = 1'b0;
    if (acc) exp_q.push_back(d);
    else begin
      checks++; errors++;
      $display("FAIL send_pixel_timeout data=%0d ready=%0b required=1", d, o_pix_ready);
    end
  endtask

  task automatic send_random(input int count, input bit gap);
    for (int i = 0; i < count; i++) send_pixel(DW'($urandom_range(0, 255)), gap);
  endtask

  task automatic wait_releases(input int target);
    int n;
    n = 0;
    while (releases < target && n < 3000) begin
      @(posedge i_clk); #1;
      n++;
    end
    checks++;
    if (releases < target) begin
      errors++;
      $display("FAIL release_timeout got=%0d required=%0d", releases, target);
    end
  endtask

  // ---------------- engine model / scoreboard ----------------
  task automatic engine_run();
    logic [DW-1:0] w1 [N];
    logic [DW-1:0] w2 [N];
    logic [DW-1:0] e1, e2;
    bit pend;
    int since;
    pend = 1'b0;
    forever begin
      if (!pend) begin
        @(posedge i_clk); #1;
      end
      if (pend || o_conv_start) begin
        pend = 1'b0;
        starts++;
        checks++;
        if (exp_q.size() < 2 * N) begin
          errors++;
          $display("FAIL sb_underflow got=%0d required=%0d", exp_q.size(), 2 * N);
        end
        for (int i = 0; i < N; i++) begin
          if (exp_q.size() > 0) w1[i] = exp_q.pop_front(); else w1[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
          if (exp_q.size() > 0) w2[i] = exp_q.pop_front(); else w2[i] = '0;
        end
        since = 0;
        for (int a = 0; a < 16; a++) begin
          i_window_addr = AW'(a);
          #1;
          e1 = '0;
          e2 = '0;
          if (a < N) begin
            e1 = w1[a];
            e2 = w2[a];
          end
          checks++;
          if (o_window1_data !== e1) begin
            errors++;
            $display("FAIL win1 pair=%0d addr=%0d got=%0d required=%0d", starts, a, o_window1_data, e1);
          end
          checks++;
          if (o_window2_data !== e2) begin
            errors++;
            $display("FAIL win2 pair=%0d addr=%0d got=%0d required=%0d", starts, a, o_window2_data, e2);
          end
          @(posedge i_clk); #1;
          since++;
        end
        while (since < done_delay || withhold) begin
          @(posedge i_clk); #1;
          since++;
        end
        eng_done = 1'b1;
        for (int h = 0; h < done_hold; h++) begin
          @(posedge i_clk); #1;
          if (o_conv_start) pend = 1'b1;
        end
        eng_done = 1'b0;
        releases++;
      end
    end
  endtask

  initial engine_run();

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int base;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_pix_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b required=1", o_pix_ready); end
    checks++; if (o_conv_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%0b required=0", o_conv_start); end
    checks++; if (o_pair_count !== 8'd0) begin errors++; $display("FAIL reset_pairs got=%0d required=0", o_pair_count); end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    for (int i = 0; i < 7; i++) send_pixel(DW'(200 + i), 1'b0);
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_pix_ready !== 1'b1) begin errors++; $display("FAIL midfill_reset_ready got=%0b required=1", o_pix_ready); end
    checks++; if (o_conv_start !== 1'b0) begin errors++; $display("FAIL midfill_reset_start got=%0b required=0", o_conv_start); end
    exp_q.delete();
    exp_pairs = 8'd0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    base = releases;
    send_random(2 * N, 1'b0);
    wait_releases(base + 1);
    exp_pairs++;
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL reset_refill_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
  endtask

  task automatic test_single_pair();
    int base;
    base = releases;
    for (int i = 1; i <= 2 * N; i++) send_pixel(DW'(i), 1'b0);
    checks++; if (o_conv_start !== 1'b0) begin errors++; $display("FAIL start_early got=%0b required=0", o_conv_start); end
    @(posedge i_clk); #1;
    checks++; if (o_conv_start !== 1'b1) begin errors++; $display("FAIL start_pulse got=%0b required=1", o_conv_start); end
    @(posedge i_clk); #1;
    checks++; if (o_conv_start !== 1'b0) begin errors++; $display("FAIL start_width got=%0b required=0", o_conv_start); end
    wait_releases(base + 1);
    exp_pairs++;
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL single_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
  endtask

  task automatic test_back_pressure();
    int base;
    int held_acc;
    base = releases;
    withhold = 1'b1;
    send_random(4 * N, 1'b0);
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%0b required=0", o_pix_ready); end
    i_pix_valid = 1'b1;
    i_pix_data  = 8'd37;
    held_acc = 0;
    repeat (8) begin
      if (o_pix_ready) held_acc++;
      @(posedge i_clk); #1;
    end
    i_pix_valid = 1'b0;
    checks++; if (held_acc != 0) begin errors++; $display("FAIL bp_held got=%0d required=0", held_acc); end
    withhold = 1'b0;
    send_pixel(8'd37, 1'b0);
    checks++; if (releases < base + 1) begin errors++; $display("FAIL bp_order got=%0d required=%0d", releases, base + 1); end
    send_random(2 * N - 1, 1'b0);
    wait_releases(base + 3);
    exp_pairs = exp_pairs + 8'd3;
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL bp_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
  endtask

  task automatic test_ping_pong();
    int base;
    int sbase;
    base = releases;
    sbase = starts;
    done_delay = 20;
    send_random(6 * N, 1'b0);
    wait_releases(base + 3);
    exp_pairs = exp_pairs + 8'd3;
    checks++; if (starts != sbase + 3) begin errors++; $display("FAIL pp_starts got=%0d required=%0d", starts, sbase + 3); end
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL pp_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
  endtask

  task automatic test_done_level();
    int base;
    int sbase;
    base = releases;
    sbase = starts;
    done_hold = 5;
    send_random(2 * N, 1'b0);
    wait_releases(base + 1);
    exp_pairs++;
    repeat (10) @(posedge i_clk);
    #1;
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL level_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
    done_hold = 1;
    tb_done = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    tb_done = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL idle_done_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
    checks++; if (starts != sbase + 1) begin errors++; $display("FAIL idle_done_starts got=%0d required=%0d", starts, sbase + 1); end
    send_random(2 * N, 1'b0);
    wait_releases(base + 2);
    exp_pairs++;
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL after_level_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
  endtask

  task automatic test_bubbles();
    int base;
    base = releases;
    send_random(20 * N, 1'b1);
    wait_releases(base + 10);
    exp_pairs = exp_pairs + 8'd10;
    checks++; if (o_pair_count !== exp_pairs) begin errors++; $display("FAIL bubble_pairs got=%0d required=%0d", o_pair_count, exp_pairs); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bubble_leftover got=%0d required=0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_pair();
    test_back_pressure();
    test_ping_pong();
    test_done_level();
    test_bubbles();
    repeat (5) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
